lcd_text_driver: RTL and testbench

//  Consumer end of the 2x16 text interface: the application hands over row_A/row_B (16 ASCII chars each)
//  and this block drives a HD44780-compatible LCD over its 4-bit write-only bus.

---
 rtl/lcd_text_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780-compatible 2x16 text driver over the 4-bit write-only bus.
// Runs the power-up init sequence once, then refreshes both lines continuously from a per-frame snapshot.
module lcd_text_driver #(
   parameter int unsigned PWRUP_CYC     = 2_000_000,
   parameter int unsigned INIT_WAIT_CYC = 500_000,
   parameter int unsigned SETUP_CYC     = 5,
   parameter int unsigned E_CYC         = 25,
   parameter int unsigned CMD_CYC       = 5_000,
   parameter int unsigned CLEAR_CYC     = 200_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] row_A,
   input  logic [127:0] row_B,
   output logic         ready,
   output logic         frame_done,
   output logic         LCD_E,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic [3:0]   LCD_D
);

   typedef enum logic [2:0] {
      T_PWRUP, T_INIT, T_CFG, T_L1_ADDR, T_L1_CHR, T_L2_ADDR, T_L2_CHR
   } top_t;

   typedef enum logic [2:0] {
      N_IDLE, N_SETUP, N_PULSE, N_HOLD, N_WAIT
   } nib_t;

   top_t          top_st, top_nxt;
   nib_t          nib_st, nib_nxt;
   logic [31:0]   cnt, cnt_nxt;
   logic [1:0]    step, step_nxt;
   logic [3:0]    idx, idx_nxt;
   logic          lo_q, lo_nxt;
   logic          is_byte_q, is_byte_nxt;
   logic          ready_nxt, fd_nxt, e_nxt, rs_nxt;
   logic [3:0]    d_nxt;
   logic          load, done, snap_en;

   logic [7:0]    req_byte;
   logic          req_rs, req_is_byte;
   logic [31:0]   req_gap;

   logic [7:0]    byte_q;
   logic [31:0]   gap_q;
   logic [127:0]  snap_a, snap_b;

   // Character i of a line; char 0 sits in the top byte.
   function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] i);
      logic [6:0] lsb;
      lsb = {~i, 3'b000};
      return line[lsb +: 8];
   endfunction

   assign LCD_RW = 1'b0;

   // Transfer requested by the current top-level state
   always_comb begin
      req_byte    = 8'h00;
      req_rs      = 1'b0;
      req_is_byte = 1'b1;
      case (top_st)
         T_INIT: begin
            req_is_byte = 1'b0;
            req_byte    = (step == 2'd3) ? 8'h20 : 8'h30;
         end
         T_CFG: begin
            case (step)
               2'd0:    req_byte = 8'h28;
               2'd1:    req_byte = 8'h0C;
               2'd2:    req_byte = 8'h06;
               default: req_byte = 8'h01;
            endcase
         end
         T_L1_ADDR: req_byte = 8'h80;
         T_L1_CHR: begin
            req_byte = char_at(snap_a, idx);
            req_rs   = 1'b1;
         end
         T_L2_ADDR: req_byte = 8'hC0;
         T_L2_CHR: begin
            req_byte = char_at(snap_b, idx);
            req_rs   = 1'b1;
         end
         default: req_byte = 8'h00;
      endcase
      if (!req_is_byte)
         req_gap = (step == 2'd0) ? INIT_WAIT_CYC : CMD_CYC;
      else
         req_gap = (req_byte == 8'h01) ? CLEAR_CYC : CMD_CYC;
   end

   // Nibble engine and top sequencer next-state
   always_comb begin
      nib_nxt     = nib_st;
      top_nxt     = top_st;
      cnt_nxt     = cnt;
      step_nxt    = step;
      idx_nxt     = idx;
      lo_nxt      = lo_q;
      is_byte_nxt = is_byte_q;
      ready_nxt   = ready;
      fd_nxt      = 1'b0;
      rs_nxt      = LCD_RS;
      d_nxt       = LCD_D;
      load        = 1'b0;
      done        = 1'b0;

      case (nib_st)
         N_IDLE: begin
            if (top_st != T_PWRUP) begin
               load        = 1'b1;
               nib_nxt     = N_SETUP;
               cnt_nxt     = SETUP_CYC - 1;
               lo_nxt      = 1'b0;
               is_byte_nxt = req_is_byte;
               rs_nxt      = req_rs;
               d_nxt       = req_byte[7:4];
            end
         end
         N_SETUP: begin
            if (cnt == '0) begin
               nib_nxt = N_PULSE;
               cnt_nxt = E_CYC - 1;
            end else cnt_nxt = cnt - 32'd1;
         end
         N_PULSE: begin
            if (cnt == '0) begin
               nib_nxt = N_HOLD;
               cnt_nxt = SETUP_CYC - 1;
            end else cnt_nxt = cnt - 32'd1;
         end
         N_HOLD: begin
            if (cnt == '0) begin
               // High nibble of a byte has no gap: straight into the low nibble's setup.
               if (is_byte_q && !lo_q) begin
                  nib_nxt = N_SETUP;
                  cnt_nxt = SETUP_CYC - 1;
                  lo_nxt  = 1'b1;
                  d_nxt   = byte_q[3:0];
               end else begin
                  nib_nxt = N_WAIT;
                  cnt_nxt = gap_q - 32'd1;
               end
            end else cnt_nxt = cnt - 32'd1;
         end
         N_WAIT: begin
            if (cnt == '0) begin
               nib_nxt = N_IDLE;
               done    = 1'b1;
            end else cnt_nxt = cnt - 32'd1;
         end
         default: nib_nxt = N_IDLE;
      endcase

      case (top_st)
         T_PWRUP: begin
            if (cnt == PWRUP_CYC - 1) begin
               top_nxt = T_INIT;
               cnt_nxt = '0;
            end else cnt_nxt = cnt + 32'd1;
         end
         T_INIT: begin
            if (done) begin
               step_nxt = step + 2'd1;
               if (step == 2'd3) top_nxt = T_CFG;
            end
         end
         T_CFG: begin
            if (done) begin
               step_nxt = step + 2'd1;
               if (step == 2'd3) begin
                  top_nxt   = T_L1_ADDR;
                  ready_nxt = 1'b1;
               end
            end
         end
         T_L1_ADDR: if (done) top_nxt = T_L1_CHR;
         T_L1_CHR: begin
            if (done) begin
               idx_nxt = idx + 4'd1;
               if (idx == 4'd15) top_nxt = T_L2_ADDR;
            end
         end
         T_L2_ADDR: if (done) top_nxt = T_L2_CHR;
         T_L2_CHR: begin
            if (done) begin
               idx_nxt = idx + 4'd1;
               if (idx == 4'd15) begin
                  top_nxt = T_L1_ADDR;
                  fd_nxt  = 1'b1;
               end
            end
         end
         default: top_nxt = T_PWRUP;
      endcase

      e_nxt   = (nib_nxt == N_PULSE);
      snap_en = (top_nxt == T_L1_ADDR) && (top_st != T_L1_ADDR);
   end

   // Control and pin registers
   always_ff @(posedge clk) begin
      if (reset) begin
         top_st     <= T_PWRUP;
         nib_st     <= N_IDLE;
         cnt        <= '0;
         step       <= '0;
         idx        <= '0;
         lo_q       <= 1'b0;
         is_byte_q  <= 1'b0;
         ready      <= 1'b0;
         frame_done <= 1'b0;
         LCD_E      <= 1'b0;
         LCD_RS     <= 1'b0;
         LCD_D      <= '0;
      end else begin
         top_st     <= top_nxt;
         nib_st     <= nib_nxt;
         cnt        <= cnt_nxt;
         step       <= step_nxt;
         idx        <= idx_nxt;
         lo_q       <= lo_nxt;
         is_byte_q  <= is_byte_nxt;
         ready      <= ready_nxt;
         frame_done <= fd_nxt;
         LCD_E      <= e_nxt;
         LCD_RS     <= rs_nxt;
         LCD_D      <= d_nxt;
      end
   end

   // Datapath registers: only meaningful once loaded, so no reset
   always_ff @(posedge clk) begin
      if (load) begin
         byte_q <= req_byte;
         gap_q  <= req_gap;
      end
      if (snap_en) begin
         snap_a <= row_A;
         snap_b <= row_B;
      end
   end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench: stimulus pushes the expected LCD write stream, a bus monitor decodes E falls and checks it.
module tb_lcd_text_driver;

   localparam int PWRUP = 20, INIT_WAIT = 10, SETUP = 2, ECYC = 3, CMD = 8, CLEAR = 12;
   localparam int FRAME_LEN = 34, INIT_LEN = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] row_A, row_B;
   logic         ready, frame_done, LCD_E, LCD_RS, LCD_RW;
   logic [3:0]   LCD_D;

   lcd_text_driver #(
      .PWRUP_CYC(PWRUP), .INIT_WAIT_CYC(INIT_WAIT), .SETUP_CYC(SETUP),
      .E_CYC(ECYC), .CMD_CYC(CMD), .CLEAR_CYC(CLEAR)
   ) dut (
      .clk(clk), .reset(reset), .row_A(row_A), .row_B(row_B),
      .ready(ready), .frame_done(frame_done), .LCD_E(LCD_E),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_D(LCD_D)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_byte;
      bit         rs;
      logic [7:0] val;
      int         min_gap;
      bit         exp_ready;
      bit         fd_after;
   } wr_t;

   wr_t q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_dec    = 0;

   function automatic void chk(string nm, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void chk_ge(string nm, longint act, longint lim);
      n_checks++;
      if (act < lim) begin
         n_fail++;
         $display("FAIL %s: got %0d, required >= %0d (t=%0t)", nm, act, lim, $time);
      end
   endfunction

   // Reference model: the write stream an HD44780 should see
   task automatic push_w(bit is_byte, bit rs, logic [7:0] v, int gap, bit rdy, bit fd);
      wr_t w;
      w.is_byte = is_byte; w.rs = rs; w.val = v;
      w.min_gap = gap; w.exp_ready = rdy; w.fd_after = fd;
      q.push_back(w);
   endtask

   task automatic push_init();
      push_w(0, 0, 8'h03, INIT_WAIT, 0, 0);
      push_w(0, 0, 8'h03, CMD, 0, 0);
      push_w(0, 0, 8'h03, CMD, 0, 0);
      push_w(0, 0, 8'h02, CMD, 0, 0);
      push_w(1, 0, 8'h28, CMD, 0, 0);
      push_w(1, 0, 8'h0C, CMD, 0, 0);
      push_w(1, 0, 8'h06, CMD, 0, 0);
      push_w(1, 0, 8'h01, CLEAR, 0, 0);
   endtask

   task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] t;
      push_w(1, 0, 8'h80, CMD, 1, 0);
      for (int i = 0; i < 16; i++) begin
         t = a >> (8 * (15 - i));
         push_w(1, 1, t[7:0], (t[7:0] == 8'h01) ? CLEAR : CMD, 1, 0);
      end
      push_w(1, 0, 8'hC0, CMD, 1, 0);
      for (int i = 0; i < 16; i++) begin
         t = b >> (8 * (15 - i));
         push_w(1, 1, t[7:0], (t[7:0] == 8'h01) ? CLEAR : CMD, 1, i == 15);
      end
   endtask

   function automatic logic [127:0] rand_row();
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r = {r[119:0], 8'($urandom_range(32, 126))};
      return r;
   endfunction

   // Bus monitor: timing checks on every nibble, decode on E falling edge
   logic       e_prev, hold_watch, have_hi, fd_pending, fd_prev, pw_armed, hi_rs;
   logic [4:0] rsd, prev_rsd;
   logic [3:0] hi;
   logic [7:0] got;
   int         e_len, low_cnt, stab, gap_req;
   wr_t        it;

   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         e_prev = 0; hold_watch = 0; have_hi = 0; fd_pending = 0; fd_prev = 0;
         pw_armed = 1; prev_rsd = '0; e_len = 0; low_cnt = 0; stab = 0; gap_req = 0;
      end else begin
         rsd  = {LCD_RS, LCD_D};
         stab = (rsd == prev_rsd) ? stab + 1 : 1;
         if (hold_watch && rsd != prev_rsd) begin
            chk_ge("rsd_hold_after_fall", low_cnt, SETUP);
            hold_watch = 0;
         end
         if (frame_done) begin
            chk("frame_done_expected", fd_pending, 1);
            chk("frame_done_width", fd_prev, 0);
            fd_pending = 0;
         end
         fd_prev = frame_done;
         if (LCD_E && !e_prev) begin
            chk_ge("rsd_setup", stab - 1, SETUP);
            chk_ge("gap_before_rise", low_cnt, gap_req);
            chk("rw_at_rise", LCD_RW, 0);
            if (pw_armed) chk_ge("pwrup_quiet", low_cnt, PWRUP);
            if (q.size() != 0) chk("ready_at_rise", ready, q[0].exp_ready);
            pw_armed = 0; hold_watch = 0; e_len = 0;
         end
         if (LCD_E) e_len++;
         if (!LCD_E && e_prev) begin
            chk("e_width", e_len, ECYC);
            chk_ge("rsd_stable_over_e", stab, SETUP + ECYC + 1);
            chk("rw_at_fall", LCD_RW, 0);
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               it = q[0];
               if (it.is_byte && !have_hi) begin
                  hi = LCD_D; hi_rs = LCD_RS; have_hi = 1; gap_req = 0;
               end else begin
                  got = it.is_byte ? {hi, LCD_D} : {4'h0, LCD_D};
                  chk("frame_done_before_next", fd_pending, 0);
                  chk("data", got, it.val);
                  chk("rs", LCD_RS, it.rs);
                  if (it.is_byte) chk("rs_high_nibble", hi_rs, it.rs);
                  chk("ready_at_fall", ready, it.exp_ready);
                  have_hi = 0; gap_req = it.min_gap; fd_pending = it.fd_after;
                  void'(q.pop_front());
                  n_dec++;
               end
            end
            hold_watch = 1; low_cnt = 0;
         end
         if (!LCD_E) low_cnt++;
         prev_rsd = rsd;
         e_prev   = LCD_E;
      end
   end

   function automatic int frame_base(int j);
      return INIT_LEN + FRAME_LEN * (j - 1);
   endfunction

   task automatic wait_dec(input int target);
      int t;
      t = 0;
      while (n_dec < target && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("wait_writes_timeout", n_dec >= target, 1);
   endtask

   task automatic check_reset_pins(string tag);
      chk({tag, "_E"}, LCD_E, 0);
      chk({tag, "_RS"}, LCD_RS, 0);
      chk({tag, "_RW"}, LCD_RW, 0);
      chk({tag, "_D"}, LCD_D, 0);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int t;
      reset = 1'b1;
      row_A = "Press BTN3 to   ";
      row_B = "show a message..";
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_pins("reset");
      push_init();
      push_frame(row_A, row_B);
      push_frame(row_A, row_B);
      @(posedge clk);
      #1 reset = 1'b0;

      // Change line 1 after the 5th char of frame 2: only frame 3 shows it
      wait_dec(frame_base(2) + 6);
      row_A = "Fibo #01 is 0000";
      push_frame(row_A, row_B);

      for (int j = 3; j <= 5; j++) begin
         wait_dec(frame_base(j) + int'($urandom_range(1, 30)));
         row_A = rand_row();
         row_B = rand_row();
         push_frame(row_A, row_B);
      end

      // Reset in the middle of line 2 of frame 6
      wait_dec(frame_base(6) + 22);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_pins("midreset");
      q.delete();
      row_A = rand_row();
      row_B = rand_row();
      push_init();
      push_frame(row_A, row_B);
      push_frame(row_A, row_B);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      t = 0;
      while (q.size() != 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("stream_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
